// File: rtl/ibex_irq_arbiter_pkg.sv
// Shared types, cause encodings and rank helpers for the interrupt arbiter.
// Rank 0 means "no interrupt"; higher ranks win.
package ibex_irq_arbiter_pkg;

    localparam int unsigned IRQ_CAUSE_W = 6;
    localparam int unsigned IRQ_DEPTH_W = 3;

    localparam logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE_NMI       = 6'h3F;
    localparam logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE_EXT       = 6'h2B;
    localparam logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE_SW        = 6'h23;
    localparam logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE_TIMER     = 6'h27;
    localparam logic [IRQ_CAUSE_W-1:0] IRQ_CAUSE_FAST_BASE = 6'h30;

    localparam int unsigned RANK_TIMER     = 1;
    localparam int unsigned RANK_SW        = 2;
    localparam int unsigned RANK_EXT       = 3;
    localparam int unsigned RANK_FAST_BASE = 4;

    typedef enum logic {
        IRQ_IDLE,
        IRQ_REQ
    } irq_state_e;

    // Source bit positions: 0 software, 1 timer, 2 external, 3+k fast k.
    function automatic int unsigned irq_src_rank(input int unsigned src);
        int unsigned rank;
        case (src)
            0:       rank = RANK_SW;
            1:       rank = RANK_TIMER;
            2:       rank = RANK_EXT;
            default: rank = RANK_FAST_BASE + (src - 3);
        endcase
        return rank;
    endfunction

    function automatic logic [IRQ_CAUSE_W-1:0] irq_rank_to_cause(
        input logic [5:0] rank,
        input logic [5:0] nmi_rank
    );
        logic [IRQ_CAUSE_W-1:0] cause;
        if (rank == nmi_rank) begin
            cause = IRQ_CAUSE_NMI;
        end else begin
            case (rank)
                6'd0:               cause = '0;
                6'(RANK_TIMER):     cause = IRQ_CAUSE_TIMER;
                6'(RANK_SW):        cause = IRQ_CAUSE_SW;
                6'(RANK_EXT):       cause = IRQ_CAUSE_EXT;
                default:            cause = IRQ_CAUSE_FAST_BASE + (rank - 6'(RANK_FAST_BASE));
            endcase
        end
        return cause;
    endfunction

endpackage

// File: rtl/ibex_irq_arbiter_if.sv
// Request/acknowledge channel between the interrupt arbiter and the core controller.
interface ibex_irq_arbiter_if;
    import ibex_irq_arbiter_pkg::*;

    logic                   req;
    logic [IRQ_CAUSE_W-1:0] cause;
    logic                   nmi_mode;
    logic [IRQ_DEPTH_W-1:0] depth;
    logic                   ack;
    logic                   done;

    modport master (output req, cause, nmi_mode, depth, input ack, done);
    modport slave  (input req, cause, nmi_mode, depth, output ack, done);

endinterface

// File: rtl/ibex_irq_nest_stack.sv
// Bounded stack of active handler ranks; a simultaneous pop and push is applied pop-first.
module ibex_irq_nest_stack #(
    parameter int unsigned NestDepth = 2,
    parameter int unsigned RankW     = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [RankW-1:0] rank_i,
    output logic [RankW-1:0] top_o,
    output logic [2:0]       depth_o
);

    logic [RankW-1:0] entries_q [NestDepth];
    logic [RankW-1:0] entries_d [NestDepth];
    logic [2:0]       depth_q, depth_d, depth_pop;
    logic             pop_en, push_en;

    always_comb begin
        pop_en    = pop_i & (depth_q != 3'd0);
        depth_pop = depth_q - {2'b00, pop_en};
        push_en   = push_i & (depth_pop < 3'(NestDepth));
        depth_d   = depth_pop + {2'b00, push_en};
        entries_d = entries_q;
        top_o     = '0;
        for (int i = 0; i < NestDepth; i++) begin
            if (push_en && (depth_pop == 3'(i))) begin
                entries_d[i] = rank_i;
            end
            if (depth_q == 3'(i + 1)) begin
                top_o = entries_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
            for (int i = 0; i < NestDepth; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            depth_q   <= depth_d;
            entries_q <= entries_d;
        end
    end

    assign depth_o = depth_q;

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Fixed-priority interrupt arbiter with edge latching, preemption and a bounded nesting stack.
module ibex_irq_arbiter
    import ibex_irq_arbiter_pkg::*;
#(
    parameter int unsigned             NumFastIrqs = 15,
    parameter int unsigned             NestDepth   = 2,
    parameter logic [NumFastIrqs-1:0]  EdgeMask    = '0,
    localparam int unsigned            NumIrqs     = NumFastIrqs + 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumIrqs-1:0] irq_i,
    input  logic               irq_nm_i,
    input  logic [NumIrqs-1:0] ie_i,
    input  logic               mstatus_mie_i,
    input  logic               debug_mode_i,
    ibex_irq_arbiter_if.master ctrl,
    output logic [NumIrqs-1:0] pending_o
);

    localparam int unsigned         RankW    = $clog2(NumIrqs + 2);
    localparam logic [RankW-1:0]    NmiRank  = RankW'(NumIrqs + 1);
    localparam logic [NumIrqs-1:0]  EdgeFull = {EdgeMask, 3'b000};

    irq_state_e             state_q, state_d;
    logic                   req_q, req_d;
    logic [RankW-1:0]       rank_q, rank_d;
    logic [IRQ_CAUSE_W-1:0] cause_q, cause_d;
    logic                   nmi_mode_q, nmi_mode_d;
    logic                   debug_q, debug_d;
    logic [NumIrqs-1:0]     irq_q, irq_d;
    logic [NumIrqs-1:0]     latch_q, latch_d;

    logic [NumIrqs-1:0]     rise, pending, ack_hit;
    logic [NumIrqs+1:0]     elig;
    logic                   mask_ok, nmi_ok, held_elig, held_nmi;
    logic                   debug_rise, ack_valid, push, pop;
    logic [RankW-1:0]       best_rank, top_rank;
    logic [IRQ_CAUSE_W-1:0] best_cause;
    logic [2:0]             stack_depth;

    always_comb begin
        rise    = irq_i & ~irq_q;
        pending = ((EdgeFull & (latch_q | rise)) | (~EdgeFull & irq_i)) & ie_i;
        mask_ok = mstatus_mie_i & ~debug_mode_i & ~nmi_mode_q & (stack_depth < 3'(NestDepth));
        nmi_ok  = irq_nm_i & ~nmi_mode_q & ~debug_mode_i;
    end

    assign elig[0]         = 1'b0;
    assign elig[NumIrqs+1] = nmi_ok;

    for (genvar i = 0; i < NumIrqs; i++) begin : gen_src
        localparam int unsigned SrcRank = irq_src_rank(i);
        assign elig[SrcRank] = pending[i] & mask_ok & (RankW'(SrcRank) > top_rank);
        assign ack_hit[i]    = (rank_q == RankW'(SrcRank));
    end

    // Ripple from lowest to highest rank so the highest eligible rank survives.
    for (genvar r = 0; r < NumIrqs + 2; r++) begin : gen_prio
        logic [RankW-1:0] best;
        if (r == 0) begin : g_base
            assign best = '0;
        end else begin : g_chain
            assign best = elig[r] ? RankW'(r) : gen_prio[r-1].best;
        end
    end

    assign best_rank  = gen_prio[NumIrqs+1].best;
    assign best_cause = irq_rank_to_cause(6'(best_rank), 6'(NmiRank));

    always_comb begin
        debug_rise = debug_mode_i & ~debug_q;
        ack_valid  = ctrl.ack & req_q & ~debug_rise;
        held_elig  = elig[rank_q];
        held_nmi   = (rank_q == NmiRank);
        state_d    = state_q;
        req_d      = req_q;
        rank_d     = rank_q;
        cause_d    = cause_q;
        if (debug_rise) begin
            state_d = IRQ_IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (best_rank != '0) begin
                        state_d = IRQ_REQ;
                        req_d   = 1'b1;
                        rank_d  = best_rank;
                        cause_d = best_cause;
                    end
                end
                IRQ_REQ: begin
                    if (ack_valid) begin
                        state_d = IRQ_IDLE;
                        req_d   = 1'b0;
                    end else if (best_rank > rank_q) begin
                        rank_d  = best_rank;
                        cause_d = best_cause;
                    end else if (!held_elig) begin
                        state_d = IRQ_IDLE;
                        req_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IRQ_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // NMI lives in nmi_mode rather than on the stack, so it can still be taken when the stack is full.
    always_comb begin
        push       = ack_valid & ~held_nmi;
        pop        = ctrl.done & ~nmi_mode_q;
        nmi_mode_d = nmi_mode_q;
        if (ctrl.done && nmi_mode_q) begin
            nmi_mode_d = 1'b0;
        end
        if (ack_valid && held_nmi) begin
            nmi_mode_d = 1'b1;
        end
        latch_d = (latch_q | rise) & EdgeFull & ~(ack_hit & {NumIrqs{ack_valid}});
        irq_d   = irq_i;
        debug_d = debug_mode_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IRQ_IDLE;
            req_q      <= 1'b0;
            rank_q     <= '0;
            cause_q    <= '0;
            nmi_mode_q <= 1'b0;
            debug_q    <= 1'b0;
            irq_q      <= '0;
            latch_q    <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rank_q     <= rank_d;
            cause_q    <= cause_d;
            nmi_mode_q <= nmi_mode_d;
            debug_q    <= debug_d;
            irq_q      <= irq_d;
            latch_q    <= latch_d;
        end
    end

    ibex_irq_nest_stack #(
        .NestDepth (NestDepth),
        .RankW     (RankW)
    ) u_nest_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .rank_i  (rank_q),
        .top_o   (top_rank),
        .depth_o (stack_depth)
    );

    assign ctrl.req      = req_q;
    assign ctrl.cause    = cause_q;
    assign ctrl.nmi_mode = nmi_mode_q;
    assign ctrl.depth    = stack_depth;
    assign pending_o     = pending;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Directed bench for ibex_irq_arbiter: 15 fast sources, nesting depth 2, fast 3 edge-triggered.
module tb_ibex_irq_arbiter;

    localparam int unsigned NumIrqs = 18;
    localparam logic [17:0] T   = 18'h00002;
    localparam logic [17:0] EXT = 18'h00004;
    localparam logic [17:0] F0  = 18'h00008;
    localparam logic [17:0] F3  = 18'h00040;
    localparam logic [17:0] F5  = 18'h00100;
    localparam logic [17:0] ALL = 18'h3FFFF;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [NumIrqs-1:0] irq;
    logic [NumIrqs-1:0] ie;
    logic               nmi;
    logic               mie;
    logic               dbg;
    logic [NumIrqs-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;

    ibex_irq_arbiter_if bus ();

    ibex_irq_arbiter #(
        .NumFastIrqs (15),
        .NestDepth   (2),
        .EdgeMask    (15'h0008)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .irq_i         (irq),
        .irq_nm_i      (nmi),
        .ie_i          (ie),
        .mstatus_mie_i (mie),
        .debug_mode_i  (dbg),
        .ctrl          (bus),
        .pending_o     (pending)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [17:0] irq_v, input logic [17:0] ie_v,
                                 input logic nmi_v, input logic mie_v, input logic dbg_v,
                                 input logic ack_v, input logic done_v);
        irq      = irq_v;
        ie       = ie_v;
        nmi      = nmi_v;
        mie      = mie_v;
        dbg      = dbg_v;
        bus.ack  = ack_v;
        bus.done = done_v;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic exp_req, input logic exp_nmi,
                               input logic [2:0] exp_depth);
        vectors++;
        assert (bus.req === exp_req) else begin
            miscompares++;
            $error("[TB] FAIL %s req: observed %0h expected %0h", tag, bus.req, exp_req);
        end
        vectors++;
        assert (bus.nmi_mode === exp_nmi) else begin
            miscompares++;
            $error("[TB] FAIL %s nmi_mode: observed %0h expected %0h", tag, bus.nmi_mode, exp_nmi);
        end
        vectors++;
        assert (bus.depth === exp_depth) else begin
            miscompares++;
            $error("[TB] FAIL %s depth: observed %0d expected %0d", tag, bus.depth, exp_depth);
        end
    endtask

    task automatic checkCause(input string tag, input logic [5:0] exp_cause);
        vectors++;
        assert (bus.cause === exp_cause) else begin
            miscompares++;
            $error("[TB] FAIL %s cause: observed %0h expected %0h", tag, bus.cause, exp_cause);
        end
    endtask

    task automatic checkPending(input string tag, input logic [17:0] exp_pend);
        vectors++;
        assert (pending === exp_pend) else begin
            miscompares++;
            $error("[TB] FAIL %s pending: observed %0h expected %0h", tag, pending, exp_pend);
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        irq      = '0;
        ie       = '0;
        nmi      = 1'b0;
        mie      = 1'b0;
        dbg      = 1'b0;
        bus.ack  = 1'b0;
        bus.done = 1'b0;
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b0, 3'd0);
        checkCause("reset", 6'h00);
        checkPending("reset", 18'h0);
        rst_ni = 1'b1;

        // Level timer request, then ack
        applyStimulus(T, T, 0, 1, 0, 0, 0);
        checkOutput("timer_req", 1'b1, 1'b0, 3'd0);
        checkCause("timer_req", 6'h27);
        checkPending("timer_pend", T);
        applyStimulus(T, T, 0, 1, 0, 1, 0);
        checkOutput("timer_ack", 1'b0, 1'b0, 3'd1);

        // External preempts timer handler; full stack then blocks fast 5
        applyStimulus(T | EXT, T | EXT, 0, 1, 0, 0, 0);
        checkOutput("ext_preempt", 1'b1, 1'b0, 3'd1);
        checkCause("ext_preempt", 6'h2B);
        applyStimulus(T | EXT, T | EXT, 0, 1, 0, 1, 0);
        checkOutput("ext_ack", 1'b0, 1'b0, 3'd2);
        applyStimulus(T | EXT | F5, T | EXT | F5, 0, 1, 0, 0, 0);
        checkOutput("full_block", 1'b0, 1'b0, 3'd2);
        applyStimulus(T | EXT | F5, T | EXT | F5, 0, 1, 0, 0, 0);
        checkOutput("full_block2", 1'b0, 1'b0, 3'd2);
        applyStimulus(T | EXT | F5, T | EXT | F5, 0, 1, 0, 0, 1);
        checkOutput("done_pop", 1'b0, 1'b0, 3'd1);
        applyStimulus(T | EXT | F5, T | EXT | F5, 0, 1, 0, 0, 0);
        checkOutput("fast5_req", 1'b1, 1'b0, 3'd1);
        checkCause("fast5_req", 6'h35);
        applyStimulus(T | EXT | F5, T | EXT | F5, 0, 1, 0, 1, 1);
        checkOutput("ack_done", 1'b0, 1'b0, 3'd1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        checkOutput("unwind", 1'b0, 1'b0, 3'd0);

        // Upgrade in REQ, then withdrawals
        applyStimulus(T, ALL, 0, 1, 0, 0, 0);
        checkCause("up_timer", 6'h27);
        applyStimulus(T | F0, ALL, 0, 1, 0, 0, 0);
        checkOutput("upgrade", 1'b1, 1'b0, 3'd0);
        checkCause("upgrade", 6'h30);
        applyStimulus(T, ALL, 0, 1, 0, 0, 0);
        checkOutput("f0_drop", 1'b0, 1'b0, 3'd0);
        applyStimulus(T, ALL, 0, 1, 0, 0, 0);
        checkOutput("timer_rereq", 1'b1, 1'b0, 3'd0);
        checkCause("timer_rereq", 6'h27);
        applyStimulus(0, ALL, 0, 1, 0, 0, 0);
        checkOutput("timer_drop", 1'b0, 1'b0, 3'd0);

        // Debug entry cancels a pending request
        applyStimulus(T, ALL, 0, 1, 0, 0, 0);
        checkOutput("dbg_pre", 1'b1, 1'b0, 3'd0);
        applyStimulus(T, ALL, 0, 1, 1, 0, 0);
        checkOutput("dbg_rise", 1'b0, 1'b0, 3'd0);
        applyStimulus(T, ALL, 0, 1, 1, 0, 0);
        checkOutput("dbg_hold", 1'b0, 1'b0, 3'd0);
        applyStimulus(0, ALL, 0, 1, 0, 0, 0);

        // Edge fast 3 latched while disabled
        applyStimulus(F3, 0, 0, 1, 0, 0, 0);
        checkOutput("edge_masked", 1'b0, 1'b0, 3'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkPending("edge_masked", 18'h0);
        ie = F3;
        #1;
        checkPending("edge_latched", F3);
        applyStimulus(0, F3, 0, 1, 0, 0, 0);
        checkOutput("edge_req", 1'b1, 1'b0, 3'd0);
        checkCause("edge_req", 6'h33);
        applyStimulus(0, F3, 0, 1, 0, 1, 0);
        checkOutput("edge_ack", 1'b0, 1'b0, 3'd1);
        checkPending("edge_cleared", 18'h0);
        applyStimulus(0, F3, 0, 1, 0, 0, 0);
        checkOutput("edge_no_rereq", 1'b0, 1'b0, 3'd1);
        applyStimulus(0, F3, 0, 1, 0, 0, 1);
        applyStimulus(0, F3, 0, 1, 0, 0, 0);
        checkOutput("edge_empty", 1'b0, 1'b0, 3'd0);

        // NMI with a full stack
        applyStimulus(T, ALL, 0, 1, 0, 0, 0);
        applyStimulus(T, ALL, 0, 1, 0, 1, 0);
        applyStimulus(T | EXT, ALL, 0, 1, 0, 0, 0);
        applyStimulus(T | EXT, ALL, 0, 1, 0, 1, 0);
        checkOutput("fill", 1'b0, 1'b0, 3'd2);
        applyStimulus(T | EXT, ALL, 1, 1, 0, 0, 0);
        checkOutput("nmi_req", 1'b1, 1'b0, 3'd2);
        checkCause("nmi_req", 6'h3F);
        applyStimulus(T | EXT, ALL, 1, 1, 0, 1, 0);
        checkOutput("nmi_ack", 1'b0, 1'b1, 3'd2);
        applyStimulus(T | EXT, ALL, 0, 1, 0, 0, 0);
        applyStimulus(T | EXT, ALL, 1, 1, 0, 0, 0);
        checkOutput("nmi_blocked", 1'b0, 1'b1, 3'd2);
        applyStimulus(T | EXT, ALL, 0, 1, 0, 0, 1);
        checkOutput("nmi_done", 1'b0, 1'b0, 3'd2);
        applyStimulus(T | EXT, ALL, 1, 1, 0, 0, 0);
        checkOutput("nmi_again", 1'b1, 1'b0, 3'd2);

        // Asynchronous reset while requesting at depth 2
        rst_ni = 1'b0;
        irq    = '0;
        ie     = '0;
        nmi    = 1'b0;
        #1;
        checkOutput("reset_async", 1'b0, 1'b0, 3'd0);
        checkCause("reset_async", 6'h00);
        checkPending("reset_async", 18'h0);
        tick();
        rst_ni = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        checkOutput("done_empty", 1'b0, 1'b0, 3'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("idle_end", 1'b0, 1'b0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
